maze_port_arbiter: RTL and testbench
====================================

# maze_port_arbiter

Round-robin arbiter that shares the single maze memory port (row/col/maze_oe/maze_we/maze_in) between NREQ solver engines. Each engine presents read or mark-write accesses through a req/gnt handshake. The arbiter registers the winning access onto the memory port and routes the returned maze_in bit back to the issuing engine with a tagged valid pulse. It sits between the solver FSMs and the maze memory model.

## Interface
- NREQ, 2: number of requesters, legal range 2..4.
- CW, 6: coordinate width; row and col are CW bits each.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester access request.
- req_we  in  NREQ  access type: 1 = write (mark cell), 0 = read.
- req_lock  in  NREQ  hold the grant for the next access of the same requester.
- req_row  in  NREQ*CW  row address; requester k occupies bits [k*CW +: CW].
- req_col  in  NREQ*CW  column address; same packing as req_row.
- gnt  out  NREQ  one-hot, combinational; transfer when req[k] & gnt[k] at a clock edge.
- rvalid  out  NREQ  one-hot, registered; read data valid for requester k.
- rdata  out  1  registered read result, meaningful only while rvalid != 0.
- row, col  out  CW each  registered memory address.
- maze_oe  out  1  registered read enable.
- maze_we  out  1  registered write enable.
- maze_in  in  1  memory read data; valid in the cycle after the edge on which maze_oe was sampled.
- stat_cnt  out  NREQ*16  per-requester grant counters (see Configuration).

## Operation
- Arbitration is combinational from req, rr_ptr, lock_valid and lock_owner.
  - Unlocked: the first requester with req set, searching from rr_ptr upward and wrapping at NREQ-1 → 0, gets gnt.
  - gnt = 0 when req = 0.
- On a transfer edge for winner k:
  - row/col are loaded from k's slice.
  - maze_oe is set to !req_we[k] and maze_we to req_we[k].
  - rr_ptr is set to (k+1) mod NREQ.
- Lock:
  - If req_lock[k] = 1 at k's transfer, lock_valid is set and lock_owner is set to k.
  - While locked, only lock_owner can be granted. Other requests wait, even while the owner is idle.
  - The lock clears on the owner's next transfer that has req_lock = 0.
  - While locked, rr_ptr does not advance.
- Cycles with no transfer: maze_oe = maze_we = 0; row/col hold their previous values.
- Read return pipeline:
  - Stage 1 registers the read flag and owner id of the issued access.
  - Stage 2 captures maze_in into rdata and drives rvalid[owner] high for exactly one cycle.
  - Writes never produce rvalid.
- One access per cycle in total. Back-to-back transfers from any mix of requesters are allowed.
- States: IDLE_UNLOCKED and LOCKED(owner). Transitions happen only on transfer edges, as described above.

## Timing
- Reset values while rst_n is low:
  - gnt = 0, rvalid = 0, rdata = 0.
  - row = col = 0, maze_oe = maze_we = 0.
  - rr_ptr = 0, lock cleared, stat_cnt = 0.
- Reset asserted mid-operation discards in-flight reads: no rvalid after reset for accesses issued before it.
- Read latency: transfer at edge E → maze_oe high E..E+1 → memory samples at E+1 → rvalid high E+2..E+3.
- Write: maze_we high for exactly the one cycle after the transfer edge.
- Requester obligations:
  - Keep req, req_we, req_lock, req_row and req_col stable until gnt is seen.
  - Do not rely on gnt while req = 0.
- Simultaneous requests: exactly one gnt bit per cycle; no requester waits more than NREQ-1 transfers while unlocked.

## Configuration
- MAZE_ARB_STATS_EN defined:
  - Each requester has a 16-bit grant counter, incremented on every transfer of that requester.
  - Counters saturate at 16'hFFFF and are cleared only by reset.
  - They are exposed on stat_cnt, requester k at [k*16 +: 16].
- Not defined: stat_cnt is constant 0 and no counter registers are built.

## Test plan
- Single read: NREQ=2, req[0] with row=3, col=5, memory cell = 1 → gnt[0] that cycle; row=3, col=5, maze_oe=1 the next cycle; rvalid=2'b01 with rdata=1 two cycles after the transfer.
- Contention: req=2'b11 held for 4 transfers after reset → grants in order 0,1,0,1; every read returns rvalid to the correct owner.
- Lock: requester 0 reads (lock=1) then writes the same cell (lock=0) while req[1] is held → requester 1 granted only after the write; maze_we=1 exactly one cycle.
- Write: req_we[1]=1 at row=63, col=0 → maze_we=1, maze_oe=0 for one cycle; rvalid stays 0.
- Reset mid-read: rst_n pulled low one cycle after a read transfer → no rvalid afterwards; all outputs 0.
- Stats (MAZE_ARB_STATS_EN): 10 transfers to requester 1 → stat_cnt[31:16]=10, stat_cnt[15:0]=0; without the macro, stat_cnt=0.

Source files
------------

// File: rtl/maze_port_arbiter.sv
// maze_port_arbiter
//   Round-robin arbiter sharing the single maze memory port between NREQ
//   solver engines. The winning access is registered onto row/col/maze_oe/
//   maze_we; read data returning on maze_in is routed back to the issuing
//   engine as a one-cycle rvalid pulse with rdata.
//
//   Handshake: a requester presents req[k] with its access fields and holds
//   them stable; a transfer happens on a rising clk edge where
//   req[k] & gnt[k] is true. gnt is combinational and never depends on the
//   access fields. Only one gnt bit is ever set.
//
//   Optional feature macro: MAZE_ARB_STATS_EN enables the per-requester
//   16-bit saturating grant counters on stat_cnt; otherwise stat_cnt is 0.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req/req_we/req_lock per-requester request, write flag, grant lock
//   req_row/req_col     packed per-requester address, [k*CW +: CW]
//   gnt                 one-hot grant (combinational)
//   rvalid, rdata       registered read return, one-hot owner
//   row, col            registered memory address
//   maze_oe, maze_we    registered read / write enables
//   maze_in             memory read data
//   stat_cnt            per-requester grant counters, [k*16 +: 16]
//   dbg_state           arbiter state: 0 = IDLE_UNLOCKED, 1 = LOCKED
module maze_port_arbiter #(
  parameter int NREQ = 2,
  parameter int CW   = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [NREQ*CW-1:0]   req_row,
  input  logic [NREQ*CW-1:0]   req_col,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic                 rdata,
  output logic [CW-1:0]        row,
  output logic [CW-1:0]        col,
  output logic                 maze_oe,
  output logic                 maze_we,
  input  logic                 maze_in,
  output logic [NREQ*16-1:0]   stat_cnt,
  output logic                 dbg_state
);

  // Requester index width; NREQ is limited to 2..4.
  localparam int PW = (NREQ > 2) ? 2 : 1;

  typedef enum logic {
    ST_IDLE_UNLOCKED = 1'b0,
    ST_LOCKED        = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_lock_owner, w_lock_owner_nxt;
  logic [PW-1:0]   r_rr_ptr, w_rr_ptr_nxt;

  logic [NREQ-1:0] w_rr_gnt;
  logic            w_rr_found;
  logic [NREQ-1:0] w_gnt;
  logic            w_xfer;
  logic [PW-1:0]   w_win;
  logic            w_we;
  logic            w_lock;
  logic [CW-1:0]   w_row;
  logic [CW-1:0]   w_col;

  logic            r_rd_p1, r_rd_p2;
  logic [PW-1:0]   r_own_p1, r_own_p2;
  logic [NREQ-1:0] w_rvalid_nxt;

  // Rotating priority: first look at requesters at or above rr_ptr, then
  // wrap around to the lowest index.
  always_comb begin
    w_rr_gnt   = '0;
    w_rr_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_rr_found && req[k] && (k >= int'(r_rr_ptr))) begin
        w_rr_gnt[k] = 1'b1;
        w_rr_found  = 1'b1;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!w_rr_found && req[k]) begin
        w_rr_gnt[k] = 1'b1;
        w_rr_found  = 1'b1;
      end
    end
  end

  // While locked only the owner may win, even if it is idle.
  always_comb begin
    w_gnt = '0;
    if (!rst_n) begin
      w_gnt = '0;
    end else if (r_state == ST_LOCKED) begin
      for (int k = 0; k < NREQ; k++) begin
        if (int'(r_lock_owner) == k) w_gnt[k] = req[k];
      end
    end else begin
      w_gnt = w_rr_gnt;
    end
  end

  assign gnt = w_gnt;

  // Winner decode: gnt is one-hot and only set where req is set.
  always_comb begin
    w_xfer = |w_gnt;
    w_win  = '0;
    w_we   = 1'b0;
    w_lock = 1'b0;
    w_row  = '0;
    w_col  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_gnt[k]) begin
        w_win  = PW'(k);
        w_we   = req_we[k];
        w_lock = req_lock[k];
        w_row  = req_row[k*CW +: CW];
        w_col  = req_col[k*CW +: CW];
      end
    end
  end

  // State changes only on transfer edges. The pointer moves past a winner
  // only for unlocked transfers (including the one that takes the lock).
  always_comb begin
    w_state_nxt      = r_state;
    w_lock_owner_nxt = r_lock_owner;
    w_rr_ptr_nxt     = r_rr_ptr;
    if (w_xfer) begin
      case (r_state)
        ST_IDLE_UNLOCKED: begin
          w_rr_ptr_nxt = (int'(w_win) == NREQ - 1) ? '0 : (w_win + PW'(1));
          if (w_lock) begin
            w_state_nxt      = ST_LOCKED;
            w_lock_owner_nxt = w_win;
          end
        end
        ST_LOCKED: begin
          if (!w_lock) w_state_nxt = ST_IDLE_UNLOCKED;
        end
        default: w_state_nxt = ST_IDLE_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE_UNLOCKED;
      r_lock_owner <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_lock_owner <= w_lock_owner_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
    end
  end

  assign dbg_state = r_state;

  always_comb begin
    w_rvalid_nxt = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_rvalid_nxt[k] = r_rd_p2 && (int'(r_own_p2) == k);
    end
  end

  // Memory port and read-return pipeline. p1 lines up with maze_oe, p2 with
  // the cycle in which maze_in carries the data, which is captured next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row      <= '0;
      col      <= '0;
      maze_oe  <= 1'b0;
      maze_we  <= 1'b0;
      r_rd_p1  <= 1'b0;
      r_own_p1 <= '0;
      r_rd_p2  <= 1'b0;
      r_own_p2 <= '0;
      rvalid   <= '0;
      rdata    <= 1'b0;
    end else begin
      maze_oe <= w_xfer & ~w_we;
      maze_we <= w_xfer & w_we;
      r_rd_p1 <= w_xfer & ~w_we;
      if (w_xfer) begin
        row      <= w_row;
        col      <= w_col;
        r_own_p1 <= w_win;
      end
      r_rd_p2  <= r_rd_p1;
      r_own_p2 <= r_own_p1;
      rvalid   <= w_rvalid_nxt;
      if (r_rd_p2) rdata <= maze_in;
    end
  end

`ifdef MAZE_ARB_STATS_EN
  logic [15:0] r_stat [NREQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREQ; k++) r_stat[k] <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (w_gnt[k] && (r_stat[k] != 16'hFFFF)) r_stat[k] <= r_stat[k] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int k = 0; k < NREQ; k++) stat_cnt[k*16 +: 16] = r_stat[k];
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_maze_port_arbiter.sv
// tb_maze_port_arbiter
//   Directed steps followed by randomized traffic against a reference model
//   of the arbiter written from its rules (pointer search, lock owner,
//   memory contents at transfer time, fixed read latency).
module tb_maze_port_arbiter;
  localparam int NREQ = 2;
  localparam int CW   = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  logic [NREQ-1:0]    req, req_we, req_lock;
  logic [NREQ*CW-1:0] req_row, req_col;
  logic [NREQ-1:0]    gnt, rvalid;
  logic               rdata;
  logic [CW-1:0]      row, col;
  logic               maze_oe, maze_we;
  logic               maze_in;
  logic [NREQ*16-1:0] stat_cnt;
  logic               dbg_state;

  maze_port_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_row(req_row), .req_col(req_col),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .row(row), .col(col), .maze_oe(maze_oe), .maze_we(maze_we),
    .maze_in(maze_in), .stat_cnt(stat_cnt), .dbg_state(dbg_state)
  );

  // Maze memory: synchronous read, write marks the cell.
  logic mem [64][64];
  always @(posedge clk) begin
    if (maze_oe) maze_in <= mem[row][col];
    if (maze_we) mem[row][col] <= 1'b1;
  end

  // ---------------- reference model ----------------
  typedef struct {
    int due;
    int owner;
    bit data;
  } rd_t;

  bit            ref_mem [64][64];
  int            m_rr;
  bit            m_locked;
  int            m_owner;
  logic [CW-1:0] m_row, m_col;
  int            m_cnt [NREQ];
  int            cyc;
  rd_t           exp_q[$];

  // Requester-side stimulus state
  bit            p_req [NREQ];
  bit            p_we [NREQ];
  bit            p_lock [NREQ];
  logic [CW-1:0] p_row [NREQ];
  logic [CW-1:0] p_col [NREQ];

  int              errors = 0;
  int              checks = 0;
  int              last_win;
  logic [NREQ-1:0] g_obs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_rr = 0; m_locked = 0; m_owner = 0; m_row = '0; m_col = '0;
    for (int k = 0; k < NREQ; k++) m_cnt[k] = 0;
    exp_q.delete();
  endfunction

  // Who should win given the current requests; -1 for nobody.
  function automatic int model_pick();
    if (!rst_n) return -1;
    if (m_locked) return p_req[m_owner] ? m_owner : -1;
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (m_rr + i) % NREQ;
      if (p_req[k]) return k;
    end
    return -1;
  endfunction

  task automatic set_acc(input int k, input bit we, input bit lk, input int r, input int c);
    p_req[k] = 1'b1; p_we[k] = we; p_lock[k] = lk;
    p_row[k] = CW'(r); p_col[k] = CW'(c);
  endtask

  function automatic logic [31:0] exp_stat(input int k);
`ifdef MAZE_ARB_STATS_EN
    return 32'(m_cnt[k]);
`else
    return 32'(k - k);
`endif
  endfunction

  // One clock cycle: drive, check gnt, clock, update model, check outputs.
  task automatic cycle();
    logic [NREQ-1:0] eg, ev;
    int w;
    rd_t e;
    for (int k = 0; k < NREQ; k++) begin
      req[k] = p_req[k]; req_we[k] = p_we[k]; req_lock[k] = p_lock[k];
      req_row[k*CW +: CW] = p_row[k];
      req_col[k*CW +: CW] = p_col[k];
    end
    #1;
    w = model_pick();
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    g_obs = gnt;
    check("gnt", 32'(gnt), 32'(eg));
    @(posedge clk);
    #1;
    cyc++;
    last_win = w;
    if (!rst_n) begin
      model_reset();
    end else if (w >= 0) begin
      m_row = p_row[w];
      m_col = p_col[w];
      if (m_cnt[w] < 65535) m_cnt[w]++;
      if (p_we[w]) ref_mem[p_row[w]][p_col[w]] = 1'b1;
      else exp_q.push_back('{due: cyc + 2, owner: w, data: ref_mem[p_row[w]][p_col[w]]});
      if (!m_locked) begin
        m_rr = (w + 1) % NREQ;
        if (p_lock[w]) begin m_locked = 1'b1; m_owner = w; end
      end else if (!p_lock[w]) begin
        m_locked = 1'b0;
      end
      p_req[w] = 1'b0;
    end
    check("row", 32'(row), 32'(m_row));
    check("col", 32'(col), 32'(m_col));
    check("maze_oe", 32'(maze_oe), 32'((w >= 0) && !p_we[(w >= 0) ? w : 0]));
    check("maze_we", 32'(maze_we), 32'((w >= 0) && p_we[(w >= 0) ? w : 0]));
    check("state", 32'(dbg_state), 32'(m_locked));
    ev = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      ev[e.owner] = 1'b1;
      check("rvalid", 32'(rvalid), 32'(ev));
      check("rdata", 32'(rdata), 32'(e.data));
    end else begin
      check("rvalid", 32'(rvalid), 32'(ev));
    end
    if (!rst_n) check("rdata_rst", 32'(rdata), 32'd0);
  endtask

  // Asynchronous reset assertion between edges; outputs must clear at once.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_row", 32'(row), 32'd0);
    check("rst_col", 32'(col), 32'd0);
    check("rst_oe", 32'(maze_oe), 32'd0);
    check("rst_we", 32'(maze_we), 32'd0);
    check("rst_stat", stat_cnt, 32'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    req = '0; req_we = '0; req_lock = '0; req_row = '0; req_col = '0;
    maze_in = 1'b0;
    cyc = 0;
    for (int r = 0; r < 64; r++) begin
      for (int c = 0; c < 64; c++) begin
        bit b;
        b = 1'($urandom_range(0, 1));
        mem[r][c] = b; ref_mem[r][c] = b;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      p_req[k] = 0; p_we[k] = 0; p_lock[k] = 0; p_row[k] = '0; p_col[k] = '0;
    end
    model_reset();

    #2;
    apply_reset();

    // Single read of a cell holding 1
    mem[3][5] = 1'b1; ref_mem[3][5] = 1'b1;
    set_acc(0, 0, 0, 3, 5);
    cycle();
    check("single_gnt", 32'(g_obs), 32'd1);
    check("single_row", 32'(row), 32'd3);
    check("single_col", 32'(col), 32'd5);
    check("single_oe", 32'(maze_oe), 32'd1);
    cycle();
    cycle();
    check("single_rvalid", 32'(rvalid), 32'd1);
    check("single_rdata", 32'(rdata), 32'd1);

    // Contention from reset: 0,1,0,1
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!p_req[k]) set_acc(k, 0, 0, 10 + i, 20 + k);
      end
      cycle();
      check("cont_gnt", 32'(g_obs), (i % 2 == 1) ? 32'd2 : 32'd1);
    end
    p_req[0] = 0; p_req[1] = 0;
    for (int i = 0; i < 3; i++) cycle();

    // Lock: 0 reads with lock, then writes same cell; 1 waits
    apply_reset();
    set_acc(0, 0, 1, 12, 12);
    set_acc(1, 0, 0, 1, 1);
    cycle();
    check("lock_gnt0", 32'(g_obs), 32'd1);
    check("lock_state", 32'(dbg_state), 32'd1);
    set_acc(0, 1, 0, 12, 12);
    cycle();
    check("lock_gnt1", 32'(g_obs), 32'd1);
    check("lock_we", 32'(maze_we), 32'd1);
    cycle();
    check("lock_gnt2", 32'(g_obs), 32'd2);
    check("lock_we_off", 32'(maze_we), 32'd0);
    for (int i = 0; i < 3; i++) cycle();

    // Write from requester 1 at the row boundary
    set_acc(1, 1, 0, 63, 0);
    cycle();
    check("wr_we", 32'(maze_we), 32'd1);
    check("wr_oe", 32'(maze_oe), 32'd0);
    check("wr_row", 32'(row), 32'd63);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("wr_rvalid", 32'(rvalid), 32'd0);
      check("wr_we_once", 32'(maze_we), 32'd0);
    end

    // Reset one cycle after a read transfer
    set_acc(1, 0, 0, 3, 5);
    cycle();
    cycle();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("rstmid_rvalid", 32'(rvalid), 32'd0);
    end

    // Stats: 10 transfers to requester 1
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      set_acc(1, 0, 0, i, i);
      cycle();
    end
`ifdef MAZE_ARB_STATS_EN
    check("stat_hi", 32'(stat_cnt[31:16]), 32'd10);
`else
    check("stat_hi", 32'(stat_cnt[31:16]), 32'd0);
`endif
    check("stat_lo", 32'(stat_cnt[15:0]), 32'd0);

    // Randomized traffic with locks, reads and writes
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!p_req[k] && ((m_locked && m_owner == k) || $urandom_range(0, 1) == 1)) begin
          set_acc(k, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7), $urandom_range(0, 7));
        end
      end
      cycle();
    end
    // Let the owner release any outstanding lock, then drain
    for (int i = 0; i < 8 && m_locked; i++) begin
      set_acc(m_owner, 0, 0, 0, 0);
      cycle();
    end
    for (int k = 0; k < NREQ; k++) p_req[k] = 0;
    for (int i = 0; i < 4; i++) cycle();
    check("drain", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < NREQ; k++) check("stat_end", 32'(stat_cnt[k*16 +: 16]), exp_stat(k));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
